aes_block_serializer: RTL
=========================

// Module: aes_block_serializer
// PURPOSE
//  Parametrised word-to-byte block serializer for the AES datapath output stage.
//  Assembles IN_W-bit core words into BLK_W-bit blocks and buffers up to DEPTH blocks.
//  Streams each block to the UART TX path as OUT_W-bit symbols, MSB- or LSB-first.
//  Decouples the core from the UART with a valid/ready input and an edge-detected TX acknowledge.
// PARAMETERS
//  IN_W      32   core word width; BLK_W % IN_W == 0
//  OUT_W     8    output symbol width; BLK_W % OUT_W == 0
//  BLK_W     128  block width
//  DEPTH     2    block buffer depth (>=1)
//  MSB_FIRST 1    1: first word -> block[BLK_W-1 -: IN_W], first symbol = block MSBs; 0: first symbol = block[OUT_W-1:0]
// PORTS
//  clk        in  1                 clock
//  rst_n      in  1                 reset, asynchronous, active-low
//  flush      in  1                 synchronous clear of all buffered/partial data
//  in_data    in  IN_W              core word
//  in_valid   in  1                 in_data valid
//  in_ready   out 1                 word accepted when in_valid & in_ready
//  out_data   out OUT_W             current symbol; 0 when out_valid=0
//  out_valid  out 1                 symbol available for UART TX
//  tx_active  in  1                 UART busy; out_valid masked while high
//  tx_done    in  1                 UART symbol complete; rising edge = ack
//  blk_count  out $clog2(DEPTH+1)   complete blocks buffered
// BEHAVIOUR
//  Reset: in_ready=0 during reset, 1 in the first cycle after release. out_valid=0, out_data=0, blk_count=0.
//  Reset also clears all pointers, word index, symbol index and the tx_done history flop.
//  Write side: words fill slot wr_ptr at word index wi (0..BLK_W/IN_W-1) in arrival order.
//  in_ready = (blk_count < DEPTH), driven from registered state only; no combinational path from tx_done.
//  Accepting the last word: the block is committed at that edge; wr_ptr wraps mod DEPTH and wi returns to 0.
//  A partial block is never visible on the output.
//  Read side FSM:
//   IDLE -> SEND when blk_count>0.
//   SEND: out_valid = ~tx_active; out_data = symbol si of slot rd_ptr.
//   On ack (tx_done & ~tx_done_q): si++.
//   On ack of the last symbol: goto POP.
//   POP (1 cycle): free slot, rd_ptr wraps, si=0, out_valid=0; -> SEND if blocks remain, else IDLE.
//  Ack outside SEND is ignored. tx_done held high counts as exactly one ack.
//  Latency: last input word at edge N with FIFO empty and IDLE gives out_valid=1 from cycle N+1 (if tx_active=0).
//  Simultaneous commit and POP free: blk_count unchanged.
//  Full (blk_count==DEPTH): in_ready=0; the word index holds.
//  flush: synchronously clears everything to the reset state.
//  flush has priority over a simultaneous accept or ack; that accept or ack is dropped.
//  Reset or flush mid-block discards the partial block; the next word starts at wi=0.
//  Elaboration: illegal divisibility or DEPTH<1 causes a $error.
// TESTING
//  T1 reset: after rst_n release, expect in_ready=1, out_valid=0, out_data=00, blk_count=0.
//  T2 MSB_FIRST=1: send 00112233,44556677,8899aabb,ccddeeff with one tx_done pulse per symbol.
//     Expect symbols 00,11,22,...,ff. out_valid rises 1 cycle after the 4th word.
//  T3 MSB_FIRST=0, same words: expect ff,ee,...,11,00.
//  T4 DEPTH=2, 3 blocks back-to-back, tx_done held low: in_ready=0 after block 2 (blk_count=2).
//     Block 3 is accepted only after the 16th ack of block 1; all 48 symbols arrive in order.
//  T5 tx_done held high 5 cycles: exactly one symbol advance. tx_active=1 forces out_valid=0.
//  T6 flush after 2 words, and flush mid-send at symbol 7: all state cleared.
//     The next full block streams from its first symbol with correct data.

Source files
------------

// File: rtl/aes_block_serializer.sv
// Word-to-symbol block serializer: packs IN_W-bit core words into BLK_W-bit blocks,
// buffers up to DEPTH blocks and streams them as OUT_W-bit symbols acked by tx_done edges.
module aes_block_serializer #(
    parameter int unsigned IN_W      = 32,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned BLK_W     = 128,
    parameter int unsigned DEPTH     = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         tx_active,
    input  logic                         tx_done,
    output logic [$clog2(DEPTH+1)-1:0]   blk_count
);

    localparam int unsigned WPB = BLK_W / IN_W;
    localparam int unsigned SPB = BLK_W / OUT_W;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WIW = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int unsigned SIW = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int unsigned SHW = $clog2(BLK_W) + 1;

    if ((BLK_W % IN_W) != 0) begin : g_bad_in_w
        $error("aes_block_serializer: BLK_W must be a multiple of IN_W");
    end
    if ((BLK_W % OUT_W) != 0) begin : g_bad_out_w
        $error("aes_block_serializer: BLK_W must be a multiple of OUT_W");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("aes_block_serializer: DEPTH must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        POP  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [PW-1:0]    wr_ptr, wr_ptr_next;
    logic [PW-1:0]    rd_ptr, rd_ptr_next;
    logic [WIW-1:0]   wi, wi_next;
    logic [SIW-1:0]   si, si_next;
    logic [CW-1:0]    blk_count_next;
    logic             in_ready_next;
    logic             tx_done_q;
    logic             ack, accept, commit, pop;

    logic [BLK_W-1:0] mem [DEPTH];
    logic [BLK_W-1:0] wr_blk;
    logic [BLK_W-1:0] rd_blk;
    logic [SHW-1:0]   wr_sh;
    logic [SHW-1:0]   rd_sh;
    logic [OUT_W-1:0] sym;

    // Words always land MSB-first inside the block; only symbol order is configurable.
    assign wr_sh  = SHW'(BLK_W - IN_W - 32'(wi) * IN_W);
    assign wr_blk = (mem[wr_ptr] & ~(BLK_W'({IN_W{1'b1}}) << wr_sh))
                  | (BLK_W'(in_data) << wr_sh);

    assign rd_sh  = MSB_FIRST ? SHW'(BLK_W - OUT_W - 32'(si) * OUT_W)
                              : SHW'(32'(si) * OUT_W);
    assign rd_blk = mem[rd_ptr];
    assign sym    = OUT_W'(rd_blk >> rd_sh);

    // Output is masked combinationally so tx_active gates it in the same cycle.
    assign out_valid = (state == SEND) && !tx_active;
    assign out_data  = out_valid ? sym : '0;

    // Next-state logic for write side, read FSM and occupancy.
    always_comb begin
        state_next     = state;
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        wi_next        = wi;
        si_next        = si;
        accept         = in_valid && in_ready;
        commit         = 1'b0;
        pop            = 1'b0;
        ack            = tx_done && !tx_done_q;

        if (accept) begin
            if (wi == WIW'(WPB - 1)) begin
                commit      = 1'b1;
                wi_next     = '0;
                wr_ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end else begin
                wi_next = wi + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (blk_count != '0) state_next = SEND;
            end
            SEND: begin
                if (ack) begin
                    if (si == SIW'(SPB - 1)) state_next = POP;
                    else                     si_next    = si + 1'b1;
                end
            end
            POP: begin
                pop         = 1'b1;
                si_next     = '0;
                rd_ptr_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            default: state_next = IDLE;
        endcase

        blk_count_next = blk_count + CW'(commit) - CW'(pop);
        if (state == POP) state_next = (blk_count_next != '0) ? SEND : IDLE;

        // Flush wins over any simultaneous accept or ack.
        if (flush) begin
            state_next     = IDLE;
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            wi_next        = '0;
            si_next        = '0;
            accept         = 1'b0;
            commit         = 1'b0;
            blk_count_next = '0;
        end

        in_ready_next = (blk_count_next < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wi        <= '0;
            si        <= '0;
            blk_count <= '0;
            in_ready  <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state     <= state_next;
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            wi        <= wi_next;
            si        <= si_next;
            blk_count <= blk_count_next;
            in_ready  <= in_ready_next;
            tx_done_q <= flush ? 1'b0 : tx_done;
        end
    end

    // Block storage needs no reset: a slot is only read after it has been fully written.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= wr_blk;
    end

endmodule
